fu_issue_select: RTL and testbench

- Read-side consumer of the per-wavefront functional-unit flags (rd_fu_simd/salu/lsu/simf) held in the issue stage.
- For each of the four functional units (SIMD, SALU, LSU, SIMF), picks one ready wavefront per offer using round-robin priority.
- Presents the pick to the unit over a valid/ready handshake.
- Reports accepted wavefronts back so the issue stage can clear their ready bits.

---
 rtl/fu_issue_select_pkg.sv | 14 +
 rtl/fu_issue_select_picker.sv | 81 ++++++++
 rtl/fu_issue_select.sv | 68 ++++++
 tb/tb_fu_issue_select.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fu_issue_select_pkg.sv
// fu_issue_select_pkg: shared sizing, functional-unit indices and picker state encoding
package fu_issue_select_pkg;
  localparam int NUM_WF  = 40;
  localparam int WF_ID_W = 6;
  localparam int NUM_FU  = 4;
  localparam int FU_SIMD = 0;
  localparam int FU_SALU = 1;
  localparam int FU_LSU  = 2;
  localparam int FU_SIMF = 3;
  typedef enum logic {ST_IDLE, ST_OFFER} pick_state_e;
  function automatic logic [WF_ID_W-1:0] next_ptr(input logic [WF_ID_W-1:0] id);
    return (int'(id) == NUM_WF - 1) ? '0 : id + WF_ID_W'(1);
  endfunction
endpackage

// File: rtl/fu_issue_select_picker.sv
// rr_wf_picker: round-robin wavefront picker with a valid/ready offer to one functional unit
module rr_wf_picker
  import fu_issue_select_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  elig,
  input  logic [NUM_WF-1:0]  wf_ready,
  input  logic               fu_ready,
  output logic               valid,
  output logic [WF_ID_W-1:0] wfid,
  output logic [NUM_WF-1:0]  issued
);
  pick_state_e        state_q, state_d;
  logic               valid_q, valid_d;
  logic [WF_ID_W-1:0] wfid_q, wfid_d;
  logic [WF_ID_W-1:0] ptr_q, ptr_d;
  logic [WF_ID_W-1:0] sel_hi, sel_lo, sel;
  logic               hit_hi, found;
  logic [NUM_WF-1:0]  offer_1h;
  logic               accept, still_ready;
  // lowest eligible index at or above the pointer, else lowest eligible overall
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    hit_hi = 1'b0;
    found  = 1'b0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_lo = WF_ID_W'(i);
        found  = 1'b1;
      end
      if (elig[i] && i >= int'(ptr_q)) begin
        sel_hi = WF_ID_W'(i);
        hit_hi = 1'b1;
      end
    end
    sel = hit_hi ? sel_hi : sel_lo;
  end
  assign offer_1h    = NUM_WF'(1) << wfid_q;
  assign still_ready = |(wf_ready & offer_1h);
  assign accept      = valid_q & fu_ready;
  // offer FSM: IDLE picks, OFFER holds until accepted or the wavefront withdraws
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    wfid_d  = wfid_q;
    ptr_d   = ptr_q;
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d = ST_OFFER;
        valid_d = 1'b1;
        wfid_d  = sel;
      end
    end else if (accept) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      ptr_d   = next_ptr(wfid_q);
    end else if (!still_ready) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end
  end
  // offer registers and round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      wfid_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      wfid_q  <= wfid_d;
      ptr_q   <= ptr_d;
    end
  end
  assign valid  = valid_q;
  assign wfid   = wfid_q;
  assign issued = accept ? offer_1h : '0;
endmodule

// File: rtl/fu_issue_select.sv
// fu_issue_select: per-unit round-robin issue selection with accepted-wavefront feedback
module fu_issue_select
  import fu_issue_select_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  wf_ready,
  input  logic [NUM_WF-1:0]  wf_fu_simd,
  input  logic [NUM_WF-1:0]  wf_fu_salu,
  input  logic [NUM_WF-1:0]  wf_fu_lsu,
  input  logic [NUM_WF-1:0]  wf_fu_simf,
  input  logic               fu_simd_ready,
  input  logic               fu_salu_ready,
  input  logic               fu_lsu_ready,
  input  logic               fu_simf_ready,
  output logic               issue_simd_valid,
  output logic               issue_salu_valid,
  output logic               issue_lsu_valid,
  output logic               issue_simf_valid,
  output logic [WF_ID_W-1:0] issue_simd_wfid,
  output logic [WF_ID_W-1:0] issue_salu_wfid,
  output logic [WF_ID_W-1:0] issue_lsu_wfid,
  output logic [WF_ID_W-1:0] issue_simf_wfid,
  output logic [NUM_WF-1:0]  issued_wf
);
  logic [NUM_WF-1:0]  fu_flag [NUM_FU];
  logic [NUM_WF-1:0]  iss     [NUM_FU];
  logic [WF_ID_W-1:0] id      [NUM_FU];
  logic [NUM_FU-1:0]  fu_rdy, val;
  logic [NUM_WF-1:0]  acc_mask_q, acc_mask_d;
  assign fu_flag[FU_SIMD] = wf_fu_simd;
  assign fu_flag[FU_SALU] = wf_fu_salu;
  assign fu_flag[FU_LSU]  = wf_fu_lsu;
  assign fu_flag[FU_SIMF] = wf_fu_simf;
  assign fu_rdy = {fu_simf_ready, fu_lsu_ready, fu_salu_ready, fu_simd_ready};
  genvar f;
  for (f = 0; f < NUM_FU; f++) begin : g_fu
    rr_wf_picker u_pick (
      .clk      (clk),
      .rst      (rst),
      .elig     (wf_ready & fu_flag[f] & ~acc_mask_q),
      .wf_ready (wf_ready),
      .fu_ready (fu_rdy[f]),
      .valid    (val[f]),
      .wfid     (id[f]),
      .issued   (iss[f])
    );
  end
  // merge per-unit accepts; ids are distinct because FU flags are one-hot
  always_comb begin
    issued_wf = '0;
    for (int k = 0; k < NUM_FU; k++) issued_wf |= iss[k];
    acc_mask_d = issued_wf;
  end
  // hide just-accepted wavefronts until the issue stage clears their ready bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_mask_q <= '0;
    else      acc_mask_q <= acc_mask_d;
  end
  assign issue_simd_valid = val[FU_SIMD];
  assign issue_salu_valid = val[FU_SALU];
  assign issue_lsu_valid  = val[FU_LSU];
  assign issue_simf_valid = val[FU_SIMF];
  assign issue_simd_wfid  = id[FU_SIMD];
  assign issue_salu_wfid  = id[FU_SALU];
  assign issue_lsu_wfid   = id[FU_LSU];
  assign issue_simf_wfid  = id[FU_SIMF];
endmodule

// File: tb/tb_fu_issue_select.sv
// tb_fu_issue_select: table-driven and directed checks of fu_issue_select
module tb_fu_issue_select;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] wf_ready = '0, wf_fu_simd = '0, wf_fu_salu = '0, wf_fu_lsu = '0, wf_fu_simf = '0;
  logic        fu_simd_ready = 1'b0, fu_salu_ready = 1'b0, fu_lsu_ready = 1'b0, fu_simf_ready = 1'b0;
  logic        issue_simd_valid, issue_salu_valid, issue_lsu_valid, issue_simf_valid;
  logic [5:0]  issue_simd_wfid, issue_salu_wfid, issue_lsu_wfid, issue_simf_wfid;
  logic [39:0] issued_wf;
  int n_cmp = 0;
  int n_bad = 0;

  fu_issue_select dut (
    .clk(clk), .rst(rst), .wf_ready(wf_ready),
    .wf_fu_simd(wf_fu_simd), .wf_fu_salu(wf_fu_salu), .wf_fu_lsu(wf_fu_lsu), .wf_fu_simf(wf_fu_simf),
    .fu_simd_ready(fu_simd_ready), .fu_salu_ready(fu_salu_ready),
    .fu_lsu_ready(fu_lsu_ready), .fu_simf_ready(fu_simf_ready),
    .issue_simd_valid(issue_simd_valid), .issue_salu_valid(issue_salu_valid),
    .issue_lsu_valid(issue_lsu_valid), .issue_simf_valid(issue_simf_valid),
    .issue_simd_wfid(issue_simd_wfid), .issue_salu_wfid(issue_salu_wfid),
    .issue_lsu_wfid(issue_lsu_wfid), .issue_simf_wfid(issue_simf_wfid),
    .issued_wf(issued_wf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0]     rw, fs, fa, fl, ff;
    logic [3:0]      u_rdy;
    logic [3:0]      e_val;
    logic [3:0][5:0] e_id;
    logic [39:0]     e_iss;
  } vec_t;

  vec_t vecs[$];
  logic [3:0]      val_v;
  logic [3:0][5:0] id_v;
  assign val_v = {issue_simf_valid, issue_lsu_valid, issue_salu_valid, issue_simd_valid};
  assign id_v  = {issue_simf_wfid, issue_lsu_wfid, issue_salu_wfid, issue_simd_wfid};

  function automatic logic [39:0] b(input int i);
    logic [39:0] one = 40'd1;
    return one << i;
  endfunction

  function automatic vec_t mk(input logic [39:0] rw, fs, fa, fl, ff, input logic [3:0] u, ev,
                              input int i0, i1, i2, i3, input logic [39:0] iss);
    vec_t v;
    v.rw = rw; v.fs = fs; v.fa = fa; v.fl = fl; v.ff = ff;
    v.u_rdy = u; v.e_val = ev;
    v.e_id = {6'(i3), 6'(i2), 6'(i1), 6'(i0)};
    v.e_iss = iss;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [39:0] rw, fs, fa, fl, ff, input logic [3:0] u);
    wf_ready = rw; wf_fu_simd = fs; wf_fu_salu = fa; wf_fu_lsu = fl; wf_fu_simf = ff;
    {fu_simf_ready, fu_lsu_ready, fu_salu_ready, fu_simd_ready} = u;
  endtask

  initial begin
    logic [39:0] s3, p4;
    s3 = b(2) | b(7) | b(39);
    p4 = b(1) | b(3) | b(4) | b(8);
    // single SALU issue, then pointer at 6 prefers 7 over 3, then wrap to 3
    vecs.push_back(mk(b(5), 0, b(5), 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(b(5), 0, b(5), 0, 0, 4'b0010, 4'b0010, 0, 5, 0, 0, b(5)));
    vecs.push_back(mk(0, 0, b(5), 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(b(3) | b(7), 0, b(3) | b(7), 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(b(3) | b(7), 0, b(3) | b(7), 0, 0, 4'b0000, 4'b0010, 0, 7, 0, 0, 0));
    vecs.push_back(mk(b(3) | b(7), 0, b(3) | b(7), 0, 0, 4'b0010, 4'b0010, 0, 7, 0, 0, b(7)));
    vecs.push_back(mk(b(3), 0, b(3) | b(7), 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(b(3), 0, b(3) | b(7), 0, 0, 4'b0010, 4'b0010, 0, 3, 0, 0, b(3)));
    vecs.push_back(mk(0, 0, b(3) | b(7), 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0));
    // SIMD round robin 2, 7, 39 then wrap back to 2
    vecs.push_back(mk(s3, s3, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(s3, s3, 0, 0, 0, 4'b0001, 4'b0001, 2, 0, 0, 0, b(2)));
    vecs.push_back(mk(b(7) | b(39), s3, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(b(7) | b(39), s3, 0, 0, 0, 4'b0001, 4'b0001, 7, 0, 0, 0, b(7)));
    vecs.push_back(mk(b(39), s3, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(b(39), s3, 0, 0, 0, 4'b0001, 4'b0001, 39, 0, 0, 0, b(39)));
    vecs.push_back(mk(b(2), s3, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(b(2), s3, 0, 0, 0, 4'b0001, 4'b0001, 2, 0, 0, 0, b(2)));
    vecs.push_back(mk(0, s3, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0));
    // all four units issue in parallel
    vecs.push_back(mk(p4, b(1), b(3), b(4), b(8), 4'b1111, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(p4, b(1), b(3), b(4), b(8), 4'b1111, 4'b1111, 1, 3, 4, 8, p4));
    vecs.push_back(mk(0, b(1), b(3), b(4), b(8), 4'b1111, 4'b0000, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset valid", 64'(val_v), 64'(0));
    chk("reset wfid", 64'(id_v), 64'(0));
    chk("reset issued", 64'(issued_wf), 64'(0));
    tick();

    foreach (vecs[k]) begin
      set_in(vecs[k].rw, vecs[k].fs, vecs[k].fa, vecs[k].fl, vecs[k].ff, vecs[k].u_rdy);
      #1;
      chk($sformatf("vec%0d valid", k), 64'(val_v), 64'(vecs[k].e_val));
      for (int u = 0; u < 4; u++)
        if (vecs[k].e_val[u]) chk($sformatf("vec%0d wfid[%0d]", k, u), 64'(id_v[u]), 64'(vecs[k].e_id[u]));
      chk($sformatf("vec%0d issued", k), 64'(issued_wf), 64'(vecs[k].e_iss));
      tick();
    end

    // LSU backpressure on wf 10 for five cycles
    set_in(b(10), 0, 0, b(10), 0, 4'b0000);
    #1 chk("bp pre valid", 64'(issue_lsu_valid), 64'(0));
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d valid", i), 64'(issue_lsu_valid), 64'(1));
      chk($sformatf("bp%0d wfid", i), 64'(issue_lsu_wfid), 64'(10));
      chk($sformatf("bp%0d issued", i), 64'(issued_wf), 64'(0));
      tick();
    end
    fu_lsu_ready = 1'b1;
    #1 chk("bp accept issued", 64'(issued_wf), 64'(b(10)));
    tick();
    set_in(0, 0, 0, 0, 0, 4'b0000);
    #1 chk("bp post valid", 64'(issue_lsu_valid), 64'(0));
    tick();

    // SIMF withdraw of wf 12; pointer stays at 9 so 12 beats 5 afterwards
    set_in(b(12), 0, 0, 0, b(12), 4'b0000);
    tick();
    #1;
    chk("wd offer valid", 64'(issue_simf_valid), 64'(1));
    chk("wd offer wfid", 64'(issue_simf_wfid), 64'(12));
    wf_ready = 0;
    #1 chk("wd no pulse", 64'(issued_wf), 64'(0));
    tick();
    #1 chk("wd valid drop", 64'(issue_simf_valid), 64'(0));
    set_in(b(5) | b(12), 0, 0, 0, b(5) | b(12), 4'b0000);
    tick();
    #1;
    chk("wd reoffer valid", 64'(issue_simf_valid), 64'(1));
    chk("wd reoffer wfid", 64'(issue_simf_wfid), 64'(12));
    fu_simf_ready = 1'b1;
    #1 chk("wd accept issued", 64'(issued_wf), 64'(b(12)));
    tick();
    set_in(0, 0, 0, 0, 0, 4'b0000);
    tick();

    // asynchronous reset in the middle of an LSU offer
    set_in(b(20), 0, 0, b(20), 0, 4'b0000);
    tick();
    #1;
    chk("rst pre valid", 64'(issue_lsu_valid), 64'(1));
    chk("rst pre wfid", 64'(issue_lsu_wfid), 64'(20));
    rst = 1'b0;
    #1 chk("rst async valid", 64'(issue_lsu_valid), 64'(0));
    fu_lsu_ready = 1'b1;
    #1 chk("rst no pulse", 64'(issued_wf), 64'(0));
    tick();
    tick();
    rst = 1'b1;
    set_in(b(3) | b(20), 0, 0, b(3) | b(20), 0, 4'b0000);
    #1 chk("rst release valid", 64'(issue_lsu_valid), 64'(0));
    tick();
    #1;
    chk("rst ptr0 valid", 64'(issue_lsu_valid), 64'(1));
    chk("rst ptr0 wfid", 64'(issue_lsu_wfid), 64'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
